// File: rtl/scrypt_smix_param_if.sv
// Handshake/data bundle for scrypt_smix_param; block width is 1024*R bits.
// The abort signal exists only when SCRYPT_SMIX_ABORT_EN is defined.
interface scrypt_smix_param_if #(
    parameter int R = 1
);
    localparam int W = 1024 * R;

    logic         enable;
    logic [W-1:0] data;
    logic [W-1:0] hash;
    logic         hash_done;
    logic         busy;
`ifdef SCRYPT_SMIX_ABORT_EN
    logic         abort;
`endif

    modport master (
`ifdef SCRYPT_SMIX_ABORT_EN
        output abort,
`endif
        output enable, output data, input hash, input hash_done, input busy
    );

    modport slave (
`ifdef SCRYPT_SMIX_ABORT_EN
        input abort,
`endif
        input enable, input data, output hash, output hash_done, output busy
    );
endinterface

// File: rtl/scrypt_smix.sv
// scrypt ROMix engine: Salsa20/8 BlockMix over a 1024*R-bit block with a 2**LOG2_N scratchpad.
// Optional job abort is compiled in when SCRYPT_SMIX_ABORT_EN is defined.
module scrypt_smix_param #(
    parameter int LOG2_N = 10,
    parameter int R      = 1
) (
    input logic                 clk,
    input logic                 n_rst,
    scrypt_smix_param_if.slave  bus
);
    localparam int W    = 1024 * R;
    localparam int NB   = 2 * R;
    localparam int N    = 1 << LOG2_N;
    localparam int SUBW = (NB > 2) ? $clog2(NB) : 1;
    localparam logic [LOG2_N:0] N_CNT    = N[LOG2_N:0];
    localparam logic [LOG2_N:0] I_ONE    = {{LOG2_N{1'b0}}, 1'b1};
    localparam logic [SUBW-1:0] SUB_LAST = SUBW'(NB - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        READ = 3'd2,
        MIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] a2, b2, c2, d2;
        b2 = b ^ rotl(a + d, 7);
        c2 = c ^ rotl(b2 + a, 9);
        d2 = d ^ rotl(c2 + b2, 13);
        a2 = a ^ rotl(d2 + c2, 18);
        return {a2, b2, c2, d2};
    endfunction

    // Column round followed by row round; word k sits at bits [511-32k -: 32].
    function automatic logic [511:0] doubleround(input logic [511:0] blk);
        logic [31:0]  x [16];
        logic [511:0] res;
        for (int k = 0; k < 16; k++) x[k] = blk[511 - 32*k -: 32];
        {x[0],  x[4],  x[8],  x[12]} = qr(x[0],  x[4],  x[8],  x[12]);
        {x[5],  x[9],  x[13], x[1]}  = qr(x[5],  x[9],  x[13], x[1]);
        {x[10], x[14], x[2],  x[6]}  = qr(x[10], x[14], x[2],  x[6]);
        {x[15], x[3],  x[7],  x[11]} = qr(x[15], x[3],  x[7],  x[11]);
        {x[0],  x[1],  x[2],  x[3]}  = qr(x[0],  x[1],  x[2],  x[3]);
        {x[5],  x[6],  x[7],  x[4]}  = qr(x[5],  x[6],  x[7],  x[4]);
        {x[10], x[11], x[8],  x[9]}  = qr(x[10], x[11], x[8],  x[9]);
        {x[15], x[12], x[13], x[14]} = qr(x[15], x[12], x[13], x[14]);
        res = '0;
        for (int k = 0; k < 16; k++) res[511 - 32*k -: 32] = x[k];
        return res;
    endfunction

    function automatic logic [511:0] add16(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] res;
        res = '0;
        for (int k = 0; k < 16; k++) res[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
        return res;
    endfunction

    state_t          state_r, state_s;
    logic [W-1:0]    x_r, ybuf_r, hash_r, rdata_r;
    logic [511:0]    s_r, bin_r;
    logic [1:0]      rnd_r;
    logic [SUBW-1:0] sub_r;
    logic [LOG2_N:0] i_r;
    logic            xor_cyc_r, done_r, busy_r;
    logic [W-1:0]    v_mem [N];

    logic            abort_s, bm_active_s, call_done_s, bm_done_s, last_iter_s;
    logic [SUBW-1:0] psub_s;
    logic [511:0]    prev_s, inp_s, dr_s, ff_s;
    logic [W-1:0]    newx_s;
    logic [LOG2_N:0] i_inc_s;
    logic [LOG2_N-1:0] j_s;
    int              src_s;

`ifdef SCRYPT_SMIX_ABORT_EN
    assign abort_s = bus.abort && (state_r != IDLE);
`else
    assign abort_s = 1'b0;
`endif

    assign bus.hash      = hash_r;
    assign bus.hash_done = done_r;
    assign bus.busy      = busy_r;

    // BlockMix datapath: Salsa input chaining, one double-round per cycle, output reordering.
    always_comb begin
        bm_active_s = (state_r == FILL) || ((state_r == MIX) && !xor_cyc_r);
        psub_s      = (sub_r == '0) ? SUB_LAST : (sub_r - SUBW'(1));
        if (sub_r == '0) begin
            prev_s = x_r[511:0];
        end else begin
            prev_s = ybuf_r[(W-1) - 512*int'(psub_s) -: 512];
        end
        inp_s       = prev_s ^ x_r[(W-1) - 512*int'(sub_r) -: 512];
        dr_s        = doubleround((rnd_r == 2'd0) ? inp_s : s_r);
        ff_s        = add16(dr_s, bin_r);
        call_done_s = bm_active_s && (rnd_r == 2'd3);
        bm_done_s   = call_done_s && (sub_r == SUB_LAST);
        i_inc_s     = i_r + I_ONE;
        last_iter_s = (i_inc_s == N_CNT);
        j_s         = x_r[480 +: LOG2_N];
        newx_s      = '0;
        src_s       = 0;
        // Even Salsa outputs land first, odd ones second; the last output is still in flight.
        for (int k = 0; k < NB; k++) begin
            src_s = (k < R) ? (2 * k) : (2 * (k - R) + 1);
            if (src_s == NB - 1) begin
                newx_s[(W-1) - 512*k -: 512] = ff_s;
            end else begin
                newx_s[(W-1) - 512*k -: 512] = ybuf_r[(W-1) - 512*src_s -: 512];
            end
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_s = state_r;
        if (abort_s) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = bus.enable ? FILL : IDLE;
                FILL:    state_s = (bm_done_s && last_iter_s) ? READ : FILL;
                READ:    state_s = MIX;
                MIX: begin
                    if (bm_done_s) begin
                        state_s = last_iter_s ? DONE : READ;
                    end else begin
                        state_s = MIX;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working block, counters and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_r       <= '0;
            ybuf_r    <= '0;
            s_r       <= '0;
            bin_r     <= '0;
            rnd_r     <= 2'd0;
            sub_r     <= '0;
            i_r       <= '0;
            xor_cyc_r <= 1'b0;
            hash_r    <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                rnd_r     <= 2'd0;
                sub_r     <= '0;
                i_r       <= '0;
                xor_cyc_r <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy_r <= bus.enable;
                        if (bus.enable) begin
                            x_r       <= bus.data;
                            i_r       <= '0;
                            rnd_r     <= 2'd0;
                            sub_r     <= '0;
                            xor_cyc_r <= 1'b0;
                        end
                    end
                    FILL, MIX: begin
                        if (xor_cyc_r) begin
                            x_r       <= x_r ^ rdata_r;
                            xor_cyc_r <= 1'b0;
                        end else begin
                            s_r   <= dr_s;
                            rnd_r <= rnd_r + 2'd1;
                            if (rnd_r == 2'd0) begin
                                bin_r <= inp_s;
                            end
                            if (call_done_s) begin
                                ybuf_r[(W-1) - 512*int'(sub_r) -: 512] <= ff_s;
                                if (bm_done_s) begin
                                    sub_r <= '0;
                                    x_r   <= newx_s;
                                    i_r   <= last_iter_s ? '0 : i_inc_s;
                                end else begin
                                    sub_r <= sub_r + SUBW'(1);
                                end
                            end
                        end
                    end
                    READ: xor_cyc_r <= 1'b1;
                    DONE: begin
                        hash_r <= x_r;
                        done_r <= 1'b1;
                    end
                    default: xor_cyc_r <= 1'b0;
                endcase
            end
        end
    end

    // Scratchpad write: snapshot X on the first cycle of every fill iteration.
    always_ff @(posedge clk) begin
        if ((state_r == FILL) && (rnd_r == 2'd0) && (sub_r == '0)) begin
            v_mem[i_r[LOG2_N-1:0]] <= x_r;
        end
    end

    // Scratchpad read, consumed by the XOR cycle at the start of MIX.
    always_ff @(posedge clk) begin
        if (state_r == READ) begin
            rdata_r <= v_mem[j_s];
        end
    end
endmodule

// File: tb/tb_scrypt_smix_param.sv
// Self-checking bench for scrypt_smix_param: two configurations against a software ROMix model.
// Abort scenario is exercised only when SCRYPT_SMIX_ABORT_EN is defined.
module tb_scrypt_smix_param;
    localparam int L1 = 1;
    localparam int R1 = 1;
    localparam int L2 = 4;
    localparam int R2 = 2;

    typedef int unsigned blk_t [16];
    typedef int unsigned bx_t [64];

    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    scrypt_smix_param_if #(.R(R1)) if1 ();
    scrypt_smix_param_if #(.R(R2)) if2 ();

    scrypt_smix_param #(.LOG2_N(L1), .R(R1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));
    scrypt_smix_param #(.LOG2_N(L2), .R(R2)) dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned rl(input int unsigned v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic blk_t salsa8(input blk_t b);
        blk_t x;
        int   q [8][4];
        int   rot [4];
        q   = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
                '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}};
        rot = '{7, 9, 13, 18};
        x = b;
        for (int dr = 0; dr < 4; dr++)
            for (int g = 0; g < 8; g++)
                for (int s = 0; s < 4; s++)
                    x[q[g][(s+1)%4]] ^= rl(x[q[g][s]] + x[q[g][(s+3)%4]], rot[s]);
        for (int k = 0; k < 16; k++) x[k] = x[k] + b[k];
        return x;
    endfunction

    function automatic bx_t blockmix(input bx_t x, input int r);
        blk_t t;
        bx_t  y;
        int   dst;
        y = '{default: 0};
        for (int k = 0; k < 16; k++) t[k] = x[(2*r-1)*16 + k];
        for (int m = 0; m < 2*r; m++) begin
            for (int k = 0; k < 16; k++) t[k] ^= x[16*m + k];
            t   = salsa8(t);
            dst = (m % 2 == 0) ? (m / 2) : (r + m / 2);
            for (int k = 0; k < 16; k++) y[16*dst + k] = t[k];
        end
        return y;
    endfunction

    function automatic bx_t romix(input bx_t b, input int r, input int log2n);
        bx_t x;
        bx_t v [$];
        int  n;
        int  j;
        n = 1 << log2n;
        x = b;
        for (int i = 0; i < n; i++) begin
            v.push_back(x);
            x = blockmix(x, r);
        end
        for (int i = 0; i < n; i++) begin
            j = int'(x[16*(2*r-1)] % n);
            for (int k = 0; k < 32*r; k++) x[k] ^= v[j][k];
            x = blockmix(x, r);
        end
        return x;
    endfunction

    // ---------------- DUT access helpers ----------------
    task automatic set_data(input int which, input bx_t w);
        for (int k = 0; k < 64; k++) begin
            if (which == 1) begin
                if (k < 32) if1.data[1023 - 32*k -: 32] = w[k];
            end else begin
                if2.data[2047 - 32*k -: 32] = w[k];
            end
        end
    endtask

    task automatic set_en(input int which, input logic v);
        if (which == 1) if1.enable = v;
        else            if2.enable = v;
    endtask

    function automatic logic get_done(input int which);
        return (which == 1) ? if1.hash_done : if2.hash_done;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 1) ? if1.busy : if2.busy;
    endfunction

    function automatic int unsigned hash_word(input int which, input int k);
        if (which == 1) return if1.hash[1023 - 32*k -: 32];
        else            return if2.hash[2047 - 32*k -: 32];
    endfunction

    // Start a job, optionally hold/re-pulse enable, wait for hash_done and check everything.
    task automatic run_job(input string tag, input int which, input bx_t din, input int hold,
                           input int repulse, input int extra, output int lat);
        int  r, l2, n, exp_lat, ndone;
        bx_t expv;
        r       = (which == 1) ? R1 : R2;
        l2      = (which == 1) ? L1 : L2;
        n       = 1 << l2;
        exp_lat = 16*r*n + 2*n + 1;
        expv    = romix(din, r, l2);
        ndone   = 0;
        lat     = 0;
        @(negedge clk);
        set_data(which, din);
        set_en(which, 1'b1);
        @(posedge clk); #1;
        check({tag, " busy_start"}, 64'(get_busy(which)), 64'd1);
        set_en(which, (hold > 1) || (repulse == 1));
        for (int e = 1; (e <= exp_lat + 40) && ((lat == 0) || (e <= lat + extra)); e++) begin
            @(posedge clk); #1;
            if (e == exp_lat - 1) check({tag, " busy_mid"}, 64'(get_busy(which)), 64'd1);
            if (get_done(which)) begin
                ndone++;
                if (lat == 0) begin
                    lat = e;
                    check({tag, " busy_at_done"}, 64'(get_busy(which)), 64'd1);
                    for (int k = 0; k < 32*r; k++)
                        check($sformatf("%s hash[%0d]", tag, k), 64'(hash_word(which, k)), 64'(expv[k]));
                end
            end
            if ((lat != 0) && (e == lat + 1)) begin
                check({tag, " done_pulse"}, 64'(get_done(which)), 64'd0);
                check({tag, " busy_fall"}, 64'(get_busy(which)), 64'd0);
            end
            set_en(which, (e + 1 < hold) || (e + 1 == repulse));
        end
        set_en(which, 1'b0);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " done_count"}, 64'(ndone), 64'd1);
    endtask

    initial begin
        bx_t d;
        bx_t d2;
        int  lat;
        n_rst      = 1'b0;
        if1.enable = 1'b0;
        if2.enable = 1'b0;
        if1.data   = '0;
        if2.data   = '0;
`ifdef SCRYPT_SMIX_ABORT_EN
        if1.abort  = 1'b0;
        if2.abort  = 1'b0;
`endif
        d  = '{default: 0};
        d2 = '{default: 0};

        // Reset held: enable toggling must not wake anything up.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if1.enable = c[0];
            if2.enable = c[0];
            @(posedge clk); #1;
            check("rst hash", 64'(|if1.hash), 64'd0);
            check("rst done", 64'(if1.hash_done), 64'd0);
            check("rst busy", 64'(if1.busy | if2.busy), 64'd0);
        end
        @(negedge clk);
        if1.enable = 1'b0;
        if2.enable = 1'b0;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst busy", 64'(if1.busy | if2.busy), 64'd0);
        check("post_rst done", 64'(if1.hash_done | if2.hash_done), 64'd0);

        for (int k = 0; k < 32; k++) d[k] = k;
        run_job("r1_seq", 1, d, 1, 0, 2, lat);

        d = '{default: 0};
        for (int k = 0; k < 64; k++) d[k] = 32'h01010101 * k;
        run_job("r2_seq", 2, d, 1, 0, 2, lat);

        for (int k = 0; k < 64; k++) d[k] = $urandom();
        run_job("r1_hold", 1, d, 20, 25, 2, lat);

        for (int k = 0; k < 64; k++) begin
            d[k]  = $urandom();
            d2[k] = $urandom();
        end
        run_job("r1_b2b_a", 1, d, 1, 0, 0, lat);
        run_job("r1_b2b_b", 1, d2, 1, 0, 2, lat);

        // Asynchronous reset in the middle of a job.
        @(negedge clk);
        for (int k = 0; k < 64; k++) d[k] = $urandom();
        set_data(1, d);
        if1.enable = 1'b1;
        @(posedge clk); #1;
        if1.enable = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_mid hash", 64'(|if1.hash), 64'd0);
        check("rst_mid done", 64'(if1.hash_done), 64'd0);
        check("rst_mid busy", 64'(if1.busy), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 64; k++) d[k] = $urandom();
        run_job("r1_after_rst", 1, d, 1, 0, 2, lat);

`ifdef SCRYPT_SMIX_ABORT_EN
        begin : abort_test
            logic [1023:0] prev_h;
            int            nd;
            prev_h = if1.hash;
            nd     = 0;
            @(negedge clk);
            for (int k = 0; k < 64; k++) d[k] = $urandom();
            set_data(1, d);
            if1.enable = 1'b1;
            @(posedge clk); #1;
            if1.enable = 1'b0;
            for (int e = 1; e < 20; e++) begin
                @(posedge clk); #1;
                if (if1.hash_done) nd++;
            end
            if1.abort = 1'b1;
            @(posedge clk); #1;
            if1.abort = 1'b0;
            check("abort busy", 64'(if1.busy), 64'd0);
            for (int e = 0; e < 45; e++) begin
                @(posedge clk); #1;
                if (if1.hash_done) nd++;
            end
            check("abort no_done", 64'(nd), 64'd0);
            check("abort hash_kept", 64'(if1.hash == prev_h), 64'd1);
            for (int k = 0; k < 64; k++) d[k] = $urandom();
            run_job("r1_after_abort", 1, d, 1, 0, 2, lat);
        end
`endif

        for (int k = 0; k < 64; k++) d[k] = $urandom();
        run_job("r2_rand", 2, d, 1, 0, 2, lat);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
